// File: rtl/axil_lbus_pkg.sv
// Shared types and constants for the AXI-Lite to local-bus bridge.
// Holds the bridge FSM state enum, AXI response codes and default bus widths.
package axil_lbus_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_WR_RESP,
        ST_RD_RESP
    } state_t;

endpackage

// File: rtl/axil_hold_buf.sv
// One-entry valid/ready holding register.
// Ports: clk, rst (async active-high); in_valid/ready/in_data upstream handshake;
//        clear empties the entry once its contents are consumed; full/data expose it.
// ready is a flop: it reads 0 in reset and tracks !full afterwards.
module axil_hold_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         ready,
    input  logic [W-1:0] in_data,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] data
);

    logic load;

    assign load = in_valid && ready;

    // Load only happens when empty and clear only when full, so they never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            ready <= 1'b0;
            data  <= '0;
        end else if (load) begin
            full  <= 1'b1;
            ready <= 1'b0;
            data  <= in_data;
        end else if (clear) begin
            full  <= 1'b0;
            ready <= 1'b1;
        end else begin
            ready <= !full;
        end
    end

endmodule

// File: rtl/axil_lbus_bridge.sv
// AXI4-Lite slave that turns each accepted read or write into one local-bus request.
// Ports: axi_aclk/axi_areset (async active-high); AXI-Lite AW/W/B/AR/R channels;
//        lb_req/lb_we/lb_addr/lb_wdata/lb_wstrb request, lb_ack/lb_rdata/lb_err completion.
// One transaction in flight; a stalled local bus is ended with SLVERR after TIMEOUT_CYC cycles.
module axil_lbus_bridge
    import axil_lbus_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                axi_aclk,
    input  logic                axi_areset,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                lb_req,
    output logic                lb_we,
    output logic [ADDR_W-1:0]   lb_addr,
    output logic [DATA_W-1:0]   lb_wdata,
    output logic [DATA_W/8-1:0] lb_wstrb,
    input  logic                lb_ack,
    input  logic [DATA_W-1:0]   lb_rdata,
    input  logic                lb_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned WBUF_W = DATA_W + STRB_W;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);

    logic              aw_full, w_full, ar_full;
    logic              aw_clr, w_clr, ar_clr;
    logic [ADDR_W-1:0] aw_data, ar_data;
    logic [WBUF_W-1:0] w_data;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               prio_wr, prio_wr_n;
    logic               wr_elig, rd_elig;
    logic [1:0]         ack_resp;

    logic               lb_req_n, lb_we_n, bvalid_n, rvalid_n;
    logic [ADDR_W-1:0]  lb_addr_n;
    logic [DATA_W-1:0]  lb_wdata_n, rdata_n;
    logic [STRB_W-1:0]  lb_wstrb_n;
    logic [1:0]         bresp_n, rresp_n;

    // Request holding buffers: accept independently, backpressure when occupied.
    axil_hold_buf #(.W(ADDR_W)) u_aw_buf (
        .clk(axi_aclk), .rst(axi_areset), .in_valid(awvalid), .ready(awready),
        .in_data(awaddr), .clear(aw_clr), .full(aw_full), .data(aw_data)
    );

    axil_hold_buf #(.W(WBUF_W)) u_w_buf (
        .clk(axi_aclk), .rst(axi_areset), .in_valid(wvalid), .ready(wready),
        .in_data({wstrb, wdata}), .clear(w_clr), .full(w_full), .data(w_data)
    );

    axil_hold_buf #(.W(ADDR_W)) u_ar_buf (
        .clk(axi_aclk), .rst(axi_areset), .in_valid(arvalid), .ready(arready),
        .in_data(araddr), .clear(ar_clr), .full(ar_full), .data(ar_data)
    );

    assign wr_elig  = aw_full && w_full;
    assign rd_elig  = ar_full;
    assign ack_resp = lb_err ? RESP_SLVERR : RESP_OKAY;

    // State and registered outputs.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            prio_wr  <= 1'b1;
            lb_req   <= 1'b0;
            lb_we    <= 1'b0;
            lb_addr  <= '0;
            lb_wdata <= '0;
            lb_wstrb <= '0;
            bvalid   <= 1'b0;
            bresp    <= '0;
            rvalid   <= 1'b0;
            rresp    <= '0;
            rdata    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            prio_wr  <= prio_wr_n;
            lb_req   <= lb_req_n;
            lb_we    <= lb_we_n;
            lb_addr  <= lb_addr_n;
            lb_wdata <= lb_wdata_n;
            lb_wstrb <= lb_wstrb_n;
            bvalid   <= bvalid_n;
            bresp    <= bresp_n;
            rvalid   <= rvalid_n;
            rresp    <= rresp_n;
            rdata    <= rdata_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        prio_wr_n  = prio_wr;
        aw_clr     = 1'b0;
        w_clr      = 1'b0;
        ar_clr     = 1'b0;
        lb_req_n   = lb_req;
        lb_we_n    = lb_we;
        lb_addr_n  = lb_addr;
        lb_wdata_n = lb_wdata;
        lb_wstrb_n = lb_wstrb;
        bvalid_n   = bvalid;
        bresp_n    = bresp;
        rvalid_n   = rvalid;
        rresp_n    = rresp;
        rdata_n    = rdata;

        case (state)
            ST_IDLE: begin
                // Round-robin only when both sides compete; a lone requester leaves the pointer alone.
                if (wr_elig && (!rd_elig || prio_wr)) begin
                    state_n    = ST_WR_REQ;
                    cnt_n      = '0;
                    lb_req_n   = 1'b1;
                    lb_we_n    = 1'b1;
                    lb_addr_n  = aw_data;
                    lb_wdata_n = w_data[DATA_W-1:0];
                    lb_wstrb_n = w_data[WBUF_W-1:DATA_W];
                    aw_clr     = 1'b1;
                    w_clr      = 1'b1;
                    if (rd_elig) prio_wr_n = 1'b0;
                end else if (rd_elig) begin
                    state_n   = ST_RD_REQ;
                    cnt_n     = '0;
                    lb_req_n  = 1'b1;
                    lb_we_n   = 1'b0;
                    lb_addr_n = ar_data;
                    ar_clr    = 1'b1;
                    if (wr_elig) prio_wr_n = 1'b1;
                end
            end

            ST_WR_REQ, ST_RD_REQ: begin
                if (lb_ack) begin
                    lb_req_n = 1'b0;
                    if (state == ST_WR_REQ) begin
                        state_n  = ST_WR_RESP;
                        bvalid_n = 1'b1;
                        bresp_n  = ack_resp;
                    end else begin
                        state_n  = ST_RD_RESP;
                        rvalid_n = 1'b1;
                        rresp_n  = ack_resp;
                        rdata_n  = lb_rdata;
                    end
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // lb_req has been high for TIMEOUT_CYC cycles: give up.
                    lb_req_n = 1'b0;
                    if (state == ST_WR_REQ) begin
                        state_n  = ST_WR_RESP;
                        bvalid_n = 1'b1;
                        bresp_n  = RESP_SLVERR;
                    end else begin
                        state_n  = ST_RD_RESP;
                        rvalid_n = 1'b1;
                        rresp_n  = RESP_SLVERR;
                        rdata_n  = '0;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            ST_WR_RESP: begin
                if (bready) begin
                    bvalid_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            end

            ST_RD_RESP: begin
                if (rready) begin
                    rvalid_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: doc/axil_lbus_bridge.md
Name: axil_lbus_bridge

Overview:
AXI4-Lite slave front-end that terminates the AXI-Lite bus driven by the fsic AXI-Lite master/testbench environment. It converts each accepted read or write into a single request on a simple local register bus (lb_*). It sits directly downstream of the AXI-Lite master and upstream of the user register banks. One outstanding transaction at a time. Local-bus stalls are bounded by a timeout that completes the transaction with SLVERR.

Parameters:
ADDR_W, 15, AXI/local address width
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT_CYC, 255, max cycles waiting for lb_ack before SLVERR; must be at least 1

Ports:
axi_aclk  in  1  clock
axi_areset  in  1  asynchronous, active-high reset
awvalid, awready  in/out  1  AW handshake
awaddr  in  ADDR_W  write address
wvalid, wready  in/out  1  W handshake
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  write strobes
bvalid  out  1  write-response valid
bready  in  1  write-response ready
bresp  out  2  write response, 00 OKAY / 10 SLVERR
arvalid, arready  in/out  1  AR handshake
araddr  in  ADDR_W  read address
rvalid  out  1  read-data valid
rready  in  1  read-data ready
rdata  out  DATA_W  read data
rresp  out  2  read response, 00 OKAY / 10 SLVERR
lb_req  out  1  local request, held until ack or timeout
lb_we  out  1  1 = write, 0 = read
lb_addr  out  ADDR_W  local address
lb_wdata  out  DATA_W  local write data
lb_wstrb  out  DATA_W/8  local write strobes
lb_ack  in  1  single-cycle completion from the register bank
lb_rdata  in  DATA_W  read data, valid with lb_ack
lb_err  in  1  error flag, valid with lb_ack

Behaviour:
- Reset (async assert, sync release): all valid/ready/req outputs 0; bresp, rresp, rdata, lb_* data fields 0; FSM in IDLE; AW/W/AR holding buffers empty; priority pointer set to write.
- Independent one-entry holding buffers for AW, W and AR:
  - awready = !aw_full; wready = !w_full; arready = !ar_full.
  - A buffer loads on the valid&&ready cycle and clears when its transaction is issued.
  - AW and W may arrive in either order or in the same cycle.
- FSM states: IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP.
- IDLE:
  - Write is eligible when aw_full && w_full. Read is eligible when ar_full.
  - If only one is eligible, take it.
  - If both are eligible, take the side indicated by the priority pointer, then toggle the pointer to the other side (round-robin, no starvation).
  - The transition drives lb_req=1 on the next cycle with the buffered fields.
- WR_REQ / RD_REQ:
  - Hold lb_req and all lb_* fields stable.
  - Timeout counter starts at 0 and increments each cycle.
  - On lb_ack: drop lb_req the same edge and go to WR_RESP / RD_RESP. Response is SLVERR if lb_err, else OKAY. For reads, capture lb_rdata.
  - If the counter reaches TIMEOUT_CYC without ack: drop lb_req, go to the response state with SLVERR; rdata = 0 for reads.
  - An lb_ack arriving after a timeout is ignored.
- WR_RESP: bvalid=1, bresp held; on bready, bvalid=0 and return to IDLE.
- RD_RESP: rvalid=1, rdata/rresp held; on rready, rvalid=0 and return to IDLE.
- Response latency: the AXI response appears one cycle after lb_ack. Best-case write latency (AW+W same cycle, immediate ack) is 3 cycles from handshake to bvalid.
- Buffers keep accepting new AW/W/AR while a transaction is in flight; their capacity of one entry provides the backpressure.
- lb_wstrb is passed through unchanged. wstrb = 0 is still issued as a write.
- Address is passed through unmodified; no alignment check.
- Reset asserted mid-transaction aborts immediately: lb_req and bvalid/rvalid drop asynchronously and buffered requests are discarded.

Decomposition:
- Package axil_lbus_pkg holds:
  - FSM state enum.
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - Default ADDR_W / DATA_W constants.
- One natural sub-module, axil_hold_buf: a one-entry valid/ready holding register parameterized by width. It is instantiated three times, for AW, W and AR.

Test Plan:
- Write 0x0004 = 0xDEADBEEF, wstrb 0xF, AW and W in the same cycle, ack after 2 cycles -> lb_we=1, lb_addr=0x0004, lb_wdata=0xDEADBEEF; bvalid with bresp=00.
- W presented 3 cycles before AW, address 0x0010 -> no lb_req until AW is accepted; then exactly one write issued.
- Read 0x0008 with lb_rdata=0x12345678, lb_err=1 -> rvalid with rdata=0x12345678, rresp=10.
- lb_ack never asserted, TIMEOUT_CYC=8 -> lb_req drops after 8 cycles; bresp=10; a late lb_ack is ignored.
- Write and read eligible together, twice in a row -> first write then read, then read then write (round-robin verified).
- Hold bready=0 for 5 cycles while a read is queued -> bvalid stays high; read not issued until bready; arready=0 once AR buffer full. Then assert axi_areset mid-read -> lb_req and rvalid are 0 immediately.
